unpacker_bp: RTL

//  Parametrised unpacker with backpressure. Accepts one wide word per cycle (up to IN_BYTES

---
 rtl/unpacker_pkg.sv | 12 +
 rtl/unpacker_beat_sel.sv | 20 ++
 rtl/unpacker_bp.sv | 102 ++++++++++
 3 files changed

// File: rtl/unpacker_pkg.sv
// unpacker_pkg: FSM state type and beat arithmetic shared by the unpacker
package unpacker_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  // number of beats needed for vbc bytes on an ob-byte bus
  function automatic logic [7:0] num_beats(input logic [7:0] vbc, input int unsigned ob);
    return 8'((32'(vbc) + ob - 1) / ob);
  endfunction
  // bytes carried by the last beat, vbc - (beats-1)*ob, for vbc >= 1
  function automatic logic [7:0] last_vbc(input logic [7:0] vbc, input int unsigned ob);
    return 8'((32'(vbc) + ob - 1) % ob + 1);
  endfunction
endpackage

// File: rtl/unpacker_beat_sel.sv
// unpacker_beat_sel: selects the current narrow beat out of the held wide word
//   held   in  IN_BYTES*8   held input word, byte i at held[i*8 +: 8]
//   beat   in  BW           beat index
//   o_data out OUT_BYTES*8  held[beat*OUT_BYTES*8 +: OUT_BYTES*8]
module unpacker_beat_sel #(
  parameter int unsigned IN_BYTES  = 160,
  parameter int unsigned OUT_BYTES = 32,
  parameter int          BW        = 3
) (
  input  logic [IN_BYTES*8-1:0]  held,
  input  logic [BW-1:0]          beat,
  output logic [OUT_BYTES*8-1:0] o_data
);
  localparam int unsigned NB = IN_BYTES / OUT_BYTES;
  always_comb begin
    o_data = held[OUT_BYTES*8-1:0];
    for (int i = 1; i < NB; i++)
      o_data = (beat == BW'(i)) ? held[i*OUT_BYTES*8 +: OUT_BYTES*8] : o_data;
  end
endmodule

// File: rtl/unpacker_bp.sv
// unpacker_bp: splits wide words into OUT_BYTES beats with backpressure and zero-bubble reload
//   clk, reset_L (sync, active-low)
//   val/sop/eop/vbc/data in, ready out           : wide input word handshake
//   o_val/o_sop/o_eop/o_vbc/o_data out, o_ready in: narrow beat handshake
//   idle out                                       : holding register empty
//   err out (only with UNPK_ERR_EN)                : sticky protocol error
module unpacker_bp
  import unpacker_pkg::*;
#(
  parameter int unsigned IN_BYTES  = 160,
  parameter int unsigned OUT_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   val,
  input  logic                   sop,
  input  logic                   eop,
  input  logic [7:0]             vbc,
  input  logic [IN_BYTES*8-1:0]  data,
  output logic                   ready,
  output logic                   o_val,
  input  logic                   o_ready,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [7:0]             o_vbc,
  output logic [OUT_BYTES*8-1:0] o_data,
  output logic                   idle
`ifdef UNPK_ERR_EN
  ,
  output logic                   err
`endif
);
  localparam int unsigned NB = IN_BYTES / OUT_BYTES;
  localparam int          BW = $clog2(NB + 1);
  state_t                state_q, state_d;
  logic [IN_BYTES*8-1:0] data_q, data_d;
  logic                  sop_q, sop_d, eop_q, eop_d;
  logic [7:0]            vbc_q, vbc_d, vbc_c;
  logic [BW-1:0]         beats_q, beats_d, beat_q, beat_d;
  logic                  last_beat, take, acc;
  assign idle  = state_q == IDLE;
  assign o_val = state_q == SEND;
  assign o_sop = o_val & sop_q & (beat_q == '0);
  assign o_eop = o_val & eop_q & last_beat;
  assign o_vbc = !o_val ? 8'd0 : last_beat ? last_vbc(vbc_q, OUT_BYTES) : 8'(OUT_BYTES);
  always_comb begin
    vbc_c     = (vbc > 8'(IN_BYTES)) ? 8'(IN_BYTES) : vbc;
    last_beat = beat_q == beats_q - BW'(1);
    take      = o_val & o_ready;
    ready     = idle | (take & last_beat);
    acc       = val & ready & (vbc != 8'd0);
    state_d   = acc ? SEND : (take & last_beat) ? IDLE : state_q;
    data_d    = acc ? data : data_q;
    sop_d     = acc ? sop : sop_q;
    eop_d     = acc ? eop : eop_q;
    vbc_d     = acc ? vbc_c : vbc_q;
    beats_d   = acc ? BW'(num_beats(vbc_c, OUT_BYTES)) : beats_q;
    beat_d    = acc ? '0 : take ? beat_q + BW'(1) : beat_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= IDLE;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vbc_q   <= 8'd0;
      beats_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vbc_q   <= vbc_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
    end
  end
  // payload needs no reset: it is only observed while o_val is high
  always_ff @(posedge clk) data_q <= data_d;
  unpacker_beat_sel #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .BW(BW)) u_sel (
    .held(data_q),
    .beat(beat_q),
    .o_data(o_data)
  );
`ifdef UNPK_ERR_EN
  logic open_q, open_d, err_q, err_d;
  always_comb begin
    open_d = acc ? !eop : open_q;
    err_d  = err_q | (acc & ((sop & open_q) | (!sop & !open_q) |
                             (vbc > 8'(IN_BYTES)) | (!eop & (vbc < 8'(IN_BYTES)))));
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      open_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`endif
endmodule
